// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write controller: FSM states, the
// init command ROM and the long-command classifier.
package lcd_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_IDLE  = 3'd5
  } lcd_state_e;

  // One byte as presented on the LCD bus
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit, 2 lines, 5x8
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, no cursor
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // entry mode: increment

  localparam int unsigned INIT_LEN = 4;
  localparam int unsigned IDX_W    = 3;

  // Init ROM lookup; out-of-range indices return 0x00
  function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      IDX_W'(0): b = LCD_FUNC_SET;
      IDX_W'(1): b = LCD_DISP_ON;
      IDX_W'(2): b = LCD_CLEAR;
      IDX_W'(3): b = LCD_ENTRY;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  // Clear and return-home need the extra settle time
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only controller. Runs the power-up wait and init
// command sequence, then writes single host bytes. All bus timing is paced
// by en_tick.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   en_tick        - one-cycle pacing pulse
//   wr_req/wr_rs/wr_data - host write request, accepted while ready=1
//   ready          - idle and able to accept a write
//   lcd_rs/lcd_rw/lcd_e/lcd_data - LCD pins (lcd_rw tied low)
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_TICKS   = 20,
  parameter int unsigned LONG_WAIT_TICKS = 2,
  parameter int unsigned CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_tick,
  input  logic       wr_req,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_TICKS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LONG_WAIT_TICKS - 1);
  localparam logic [IDX_W-1:0] INIT_END  = IDX_W'(INIT_LEN);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  lcd_byte_t        byte_q, byte_d;
  logic             e_d, ready_d;
  logic             exit_now;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    exit_now = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (en_tick) begin
          if (cnt_q == PWR_LAST) exit_now = 1'b1;
          else                   cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_SETUP: begin
        if (en_tick) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (en_tick) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (en_tick) begin
          if (is_long_cmd(byte_q.rs, byte_q.data)) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            exit_now = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (en_tick) begin
          if (cnt_q == WAIT_LAST) exit_now = 1'b1;
          else                    cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        // Host acceptance is not paced; the coinciding tick is not counted
        if (wr_req) begin
          state_d     = ST_SETUP;
          byte_d.rs   = wr_rs;
          byte_d.data = wr_data;
        end
      end
      default: state_d = ST_PWRUP;
    endcase

    // Shared exit: next init byte if any remain, otherwise idle.
    // Power-up exit lands here with idx=0, loading the first ROM entry.
    if (exit_now) begin
      cnt_d = '0;
      if (idx_q != INIT_END) begin
        state_d     = ST_SETUP;
        byte_d.rs   = 1'b0;
        byte_d.data = init_byte(idx_q);
        idx_d       = idx_q + IDX_W'(1);
      end else begin
        state_d = ST_IDLE;
      end
    end

    e_d     = (state_d == ST_PULSE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      lcd_e   <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      lcd_e   <= e_d;
      ready   <= ready_d;
    end
  end

  assign lcd_rs   = byte_q.rs;
  assign lcd_data = byte_q.data;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl. A tick-level model predicts
// every E pulse (byte and tick number) and the ready level each cycle.
module tb_lcd_hd44780_ctrl;

  localparam int TICK_PER = 10;
  localparam int PWR      = 20;
  localparam int LW       = 2;

  logic       clk = 1'b0;
  logic       rst, en_tick, wr_req, wr_rs;
  logic [7:0] wr_data;
  logic       ready, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .POWERUP_TICKS  (PWR),
    .LONG_WAIT_TICKS(LW),
    .CNT_W          (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en_tick (en_tick),
    .wr_req  (wr_req),
    .wr_rs   (wr_rs),
    .wr_data (wr_data),
    .ready   (ready),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .lcd_data(lcd_data)
  );

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         k;
  } pulse_t;

  pulse_t     q[$];
  pulse_t     cur;
  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         n_cmp = 0, n_err = 0;
  int         tick_k = 0, phase = 0, ready_tick = 0, accepts = 0, e_len = 0;
  logic       m_ready = 1'b0, prev_e = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_long(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && (d >= 8'h01) && (d <= 8'h03);
  endfunction

  // A byte whose SETUP begins at tick s: E high from tick s+1, ready after s+3 (+LW if long)
  task automatic schedule(input logic rs, input logic [7:0] d, input int s);
    pulse_t p;
    p.rs = rs; p.d = d; p.k = s + 1;
    q.push_back(p);
    ready_tick = s + 3 + (is_long(rs, d) ? LW : 0);
  endtask

  task automatic init_model();
    int s;
    q.delete();
    tick_k = 0; m_ready = 1'b0; prev_e = 1'b0;
    s = PWR;
    for (int i = 0; i < 4; i++) begin
      schedule(1'b0, rom[i], s);
      s = ready_tick;
    end
  endtask

  // One clock: drive tick, step model at the edge, check outputs 1 time unit later
  task automatic cycle();
    logic t, req, rs_e;
    logic [7:0] d_e;
    en_tick = (phase == TICK_PER - 1);
    phase   = (phase + 1) % TICK_PER;
    t = en_tick; req = wr_req; rs_e = wr_rs; d_e = wr_data;
    @(posedge clk); #1;
    if (rst) begin
      if (t) tick_k++;
      if (m_ready && req) begin
        m_ready = 1'b0;
        accepts++;
        schedule(rs_e, d_e, tick_k);
      end else if (!m_ready && t && tick_k == ready_tick) begin
        m_ready = 1'b1;
      end
      chk("ready", ready, m_ready);
      chk("lcd_rw", lcd_rw, 0);
      if (lcd_e && !prev_e) begin
        if (q.size() == 0) chk("spurious_e", lcd_e, 0);
        else begin
          cur = q.pop_front();
          e_len = 1;
          chk("e_rise_tick", tick_k, cur.k);
          chk("e_rs", lcd_rs, cur.rs);
          chk("e_data", lcd_data, cur.d);
        end
      end else if (lcd_e) begin
        e_len++;
        chk("e_hold_rs", lcd_rs, cur.rs);
        chk("e_hold_data", lcd_data, cur.d);
      end else if (prev_e) begin
        chk("e_width", e_len, TICK_PER);
        chk("e_fall_tick", tick_k, cur.k + 1);
      end
      prev_e = lcd_e;
    end
  endtask

  task automatic wait_ready(input int lim);
    int n = 0;
    while (!m_ready && n < lim) begin cycle(); n++; end
    n_cmp++;
    assert (m_ready === 1'b1) else begin
      n_err++;
      $error("FAIL ready_timeout: observed %0b expected 1 within %0d cycles", m_ready, lim);
    end
  endtask

  task automatic host_write(input logic rs, input logic [7:0] d);
    wait_ready(300);
    wr_rs = rs; wr_data = d; wr_req = 1'b1;
    cycle();
    wr_req = 1'b0; wr_data = 8'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_e"}, lcd_e, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_rs"}, lcd_rs, 0);
    chk({tag, "_rw"}, lcd_rw, 0);
    chk({tag, "_data"}, lcd_data, 8'h00);
  endtask

  initial begin
    int base, n;
    logic [7:0] d;
    rst = 1'b0; en_tick = 1'b0; wr_req = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;

    // Reset state, then full init sequence
    repeat (3) cycle();
    check_reset_vals("rst0");
    rst = 1'b1;
    init_model();
    wait_ready(600);

    // Character write, then long and plain commands
    host_write(1'b1, 8'h41);
    wait_ready(100);
    host_write(1'b0, 8'h01);
    wait_ready(100);
    host_write(1'b0, 8'h80);
    wait_ready(100);
    host_write(1'b1, 8'h02);
    wait_ready(100);

    // Acceptance on a tick cycle: that tick does not advance the write
    wait_ready(100);
    n = 0;
    while (phase != TICK_PER - 1 && n < TICK_PER) begin cycle(); n++; end
    host_write(1'b1, 8'h5A);
    wait_ready(100);

    // wr_req held across two ready windows: exactly one write per window
    base = accepts;
    wr_rs = 1'b1; wr_data = 8'h31; wr_req = 1'b1;
    n = 0;
    while (accepts < base + 2 && n < 400) begin
      cycle(); n++;
      if (accepts == base + 1) wr_data = 8'h32;
    end
    wr_req = 1'b0;
    chk("held_req_accepts", accepts - base, 2);
    wait_ready(100);

    // Randomized writes with random idle gaps
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 15)) cycle();
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      host_write(1'($urandom), d);
    end
    wait_ready(100);

    // Reset while E is high, with wr_req held through the restarted init
    host_write(1'b1, 8'h7E);
    n = 0;
    while (!lcd_e && n < 60) begin cycle(); n++; end
    chk("pre_rst_e_high", lcd_e, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_e", lcd_e, 0);
    chk("async_rst_ready", ready, 0);
    repeat (3) cycle();
    check_reset_vals("rst1");
    rst = 1'b1;
    init_model();
    base = accepts;
    wr_rs = 1'b1; wr_data = 8'h23; wr_req = 1'b1;
    n = 0;
    while (accepts == base && n < 600) begin cycle(); n++; end
    wr_req = 1'b0;
    chk("post_rst_accept", accepts - base, 1);
    wait_ready(100);
    repeat (20) cycle();
    chk("pending_pulses", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
